bid_arbiter_n: RTL
==================

Name: bid_arbiter_n

Overview:
Parametrised successor of the three-bidder auction controller. Supports N bidders with configurable amount and balance widths, a programmable round length that ends the round automatically, funds checking, and a counted bad-key lockout. It sits between the host control interface (C_*) and N bidder ports. All outputs are registered.

Parameters:
N, 4, number of bidders (2..8)
AW, 16, bid amount width per bidder
BW, 32, balance/accumulator width (BW >= AW+1)
IW, $clog2(N), bidder index width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
C_op  in  4  opcode
C_data  in  32  opcode operand
C_idx  in  IW  bidder index for LoadBal
C_start  in  1  round active request (level)
bid  in  N  per-bidder bid strobe
retract  in  N  per-bidder retract strobe
bid_amt  in  N*AW  per-bidder amount; bidder i uses [i*AW +: AW]
ack  out  N  bid accepted (1-cycle pulse)
bid_err  out  2*N  per-bidder error: 00 ok, 01 round inactive, 10 insufficient funds/over-retract, 11 masked or bid+retract
balance  out  N*BW  committed balances
win  out  N  one-hot winner, valid while round_over=1
ready  out  1  accepts commands
err  out  3  000 ok, 001 bad key, 010 already unlocked, 011 start while unlocked, 100 invalid op
round_over  out  1  result valid
max_bid  out  BW  winning total

Behaviour:
- Opcodes (shared package): 0 NOP, 1 Unlock, 2 Lock, 3 LoadBal, 4 SetMask, 5 SetTimer, 6 BidCharge, 7 SetRoundLen; all others return err=100.
- Reset: state=UNLOCKED, balances=0, mask=all ones, timer=15, key=0, cost=1, round_len=0 (0 = unlimited). All outputs are 0.
- Every output and register updates on the clk edge after the input cycle (latency 1).
- UNLOCKED: ready=1. Config opcodes write their register. LoadBal writes balance[C_idx]; C_idx >= N gives err=100. SetMask uses C_data[N-1:0]. SetTimer uses C_data[3:0]. Lock stores key=C_data and moves to LOCKED. Unlock gives err=010. C_start=1 gives err=011 and takes priority over all opcodes. Any bid gives bid_err=01.
- LOCKED: C_start=1 loads tmp_bal[i]=balance[i] and clears tot[i], chg[i] and round counter, then moves to ACTIVE. Unlock with matching key moves to UNLOCKED. Unlock with wrong key gives err=001 and moves to LOCKOUT. Any other non-NOP opcode gives err=100.
- LOCKOUT: ready=0, down-counter loaded with timer. Returns to LOCKED when the counter reaches 0. timer=0 means exit on the next cycle. All commands are ignored. err holds 001.
- ACTIVE (each cycle, each bidder i independently):
  - mask[i]=0 with bid or retract: bid_err=11, no change.
  - bid and retract together: bid_err=11 and err=100.
  - bid only: accept if tmp_bal >= amt+cost. On accept, ack=1, tot+=amt, chg+=cost, tmp_bal-=amt+cost. Otherwise bid_err=10.
  - retract only: accept if tot >= amt and tmp_bal >= cost. On accept, tot-=amt, tmp_bal+=amt-cost, chg+=cost. Otherwise bid_err=10. Retract never sets ack.
  - Round counter increments each cycle. The round ends when C_start=0, or when round_len != 0 and the count reaches round_len-1; then the state moves to OVER. A bid in the final cycle is still processed.
- OVER (entered once; the result is computed on entry):
  - Winner = max tot; ties go to the lowest index. If all tot=0, win=0 and max_bid=0.
  - Winner: balance = tmp_bal. Losers: balance = balance - chg (bid refunded, charges kept).
  - round_over=1 and win/max_bid are held until the state leaves OVER.
  - C_start=1 starts a new round (to ACTIVE). Unlock follows the LOCKED rules. NOP stays in OVER. Other opcodes give err=100 and move to LOCKED.
- All arithmetic is unsigned BW bits; amounts are zero-extended. Funds checks make underflow impossible.
- reset mid-round discards the round: all balances, config and outputs return to reset values.

Decomposition:
- Package bid_pkg: opcode enum, state enum {UNLOCKED, LOCKED, LOCKOUT, ACTIVE, OVER}, err and bid_err localparams.
- Sub-module bid_lane (one per bidder, generate loop): holds tmp_bal/tot/chg and per-lane accept logic.
- The top level holds the FSM, config registers and the winner max-tree.

Test Plan:
- N=4. Reset, LoadBal idx2=100, Lock key=5, Unlock key=5 → balance[2]=100, state UNLOCKED, err=000.
- Lock key=5, Unlock key=7, timer=3 → err=001, ready=0 for 3 cycles, then ready=1 in LOCKED.
- Balances 50/50/50/50, cost=1. Bidder0 bids 20, bidder1 bids 20, C_start drops → win=0001, max_bid=20, balance0=29, balance1=49.
- Balance 10, cost=1, bid 10 → bid_err=10, ack=0, tot unchanged.
- round_len=4, C_start held, bids each cycle → OVER entered after the 4th cycle with round_over=1.
- mask=1110, bidder0 bids → bid_err=11. Bidder3 bids and retracts in the same cycle → bid_err=11, err=100.

Source files
------------

// File: rtl/bid_pkg.sv
// Shared definitions for the N-bidder auction controller: opcodes, FSM states,
// host and per-bidder error codes, and reset values of the config registers.
package bid_pkg;

    typedef enum logic [3:0] {
        OP_NOP         = 4'd0,
        OP_UNLOCK      = 4'd1,
        OP_LOCK        = 4'd2,
        OP_LOADBAL     = 4'd3,
        OP_SETMASK     = 4'd4,
        OP_SETTIMER    = 4'd5,
        OP_BIDCHARGE   = 4'd6,
        OP_SETROUNDLEN = 4'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_UNLOCKED,
        ST_LOCKED,
        ST_LOCKOUT,
        ST_ACTIVE,
        ST_OVER
    } state_e;

    localparam logic [2:0] ERR_OK       = 3'b000;
    localparam logic [2:0] ERR_BADKEY   = 3'b001;
    localparam logic [2:0] ERR_UNLOCKED = 3'b010;
    localparam logic [2:0] ERR_START    = 3'b011;
    localparam logic [2:0] ERR_INVOP    = 3'b100;

    localparam logic [1:0] BE_OK       = 2'b00;
    localparam logic [1:0] BE_INACTIVE = 2'b01;
    localparam logic [1:0] BE_FUNDS    = 2'b10;
    localparam logic [1:0] BE_REJECT   = 2'b11;

    localparam logic [3:0] RST_TIMER = 4'd15;

endpackage

// File: rtl/bid_arbiter_n_lane.sv
// One bidder lane: in-round scratch balance, bid total and accumulated charges,
// plus the accept/reject decision for that bidder's bid or retract strobe.
module bid_lane
    import bid_pkg::*;
#(
    parameter int AW = 16,
    parameter int BW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_active,
    input  logic          i_mask,
    input  logic          i_bid,
    input  logic          i_retract,
    input  logic [AW-1:0] i_amt,
    input  logic [BW-1:0] i_cost,
    input  logic [BW-1:0] i_bal,
    output logic [BW-1:0] o_tmp_nxt,
    output logic [BW-1:0] o_tot_nxt,
    output logic [BW-1:0] o_chg_nxt,
    output logic          o_ack_nxt,
    output logic [1:0]    o_berr_nxt
);

    logic [BW-1:0] r_tmp;
    logic [BW-1:0] r_tot;
    logic [BW-1:0] r_chg;
    logic [BW-1:0] w_tmp;
    logic [BW-1:0] w_tot;
    logic [BW-1:0] w_chg;
    logic          w_ack;
    logic [1:0]    w_berr;
    logic [BW-1:0] w_amt;
    logic [BW:0]   w_need;
    logic          w_bid_ok;
    logic          w_ret_ok;

    // Sum carried one bit wider so a large charge cannot wrap and pass the check.
    assign w_amt    = BW'(i_amt);
    assign w_need   = {1'b0, w_amt} + {1'b0, i_cost};
    assign w_bid_ok = ({1'b0, r_tmp} >= w_need);
    assign w_ret_ok = (r_tot >= w_amt) && (r_tmp >= i_cost);

    always_comb begin
        w_tmp  = r_tmp;
        w_tot  = r_tot;
        w_chg  = r_chg;
        w_ack  = 1'b0;
        w_berr = BE_OK;
        if (i_active) begin
            if (i_bid || i_retract) begin
                if (!i_mask || (i_bid && i_retract)) begin
                    w_berr = BE_REJECT;
                end else if (i_bid) begin
                    if (w_bid_ok) begin
                        w_ack = 1'b1;
                        w_tot = r_tot + w_amt;
                        w_chg = r_chg + i_cost;
                        w_tmp = r_tmp - w_amt - i_cost;
                    end else begin
                        w_berr = BE_FUNDS;
                    end
                end else begin
                    if (w_ret_ok) begin
                        w_tot = r_tot - w_amt;
                        w_chg = r_chg + i_cost;
                        w_tmp = r_tmp + w_amt - i_cost;
                    end else begin
                        w_berr = BE_FUNDS;
                    end
                end
            end
        end else begin
            if (i_bid || i_retract) begin
                w_berr = BE_INACTIVE;
            end
            if (i_load) begin
                w_tmp = i_bal;
                w_tot = '0;
                w_chg = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmp <= '0;
            r_tot <= '0;
            r_chg <= '0;
        end else begin
            r_tmp <= w_tmp;
            r_tot <= w_tot;
            r_chg <= w_chg;
        end
    end

    assign o_tmp_nxt  = w_tmp;
    assign o_tot_nxt  = w_tot;
    assign o_chg_nxt  = w_chg;
    assign o_ack_nxt  = w_ack;
    assign o_berr_nxt = w_berr;

endmodule

// File: rtl/bid_arbiter_n.sv
// N-bidder auction controller: host command FSM, config registers, committed
// balances and the end-of-round winner selection across the bidder lanes.
module bid_arbiter_n
    import bid_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 16,
    parameter int BW = 32,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      C_op,
    input  logic [31:0]     C_data,
    input  logic [IW-1:0]   C_idx,
    input  logic            C_start,
    input  logic [N-1:0]    bid,
    input  logic [N-1:0]    retract,
    input  logic [N*AW-1:0] bid_amt,
    output logic [N-1:0]    ack,
    output logic [2*N-1:0]  bid_err,
    output logic [N*BW-1:0] balance,
    output logic [N-1:0]    win,
    output logic            ready,
    output logic [2:0]      err,
    output logic            round_over,
    output logic [BW-1:0]   max_bid
);

    state_e        r_state;
    state_e        w_state_nxt;
    op_e           w_op;

    logic [31:0]   r_key;
    logic [31:0]   w_key_nxt;
    logic [N-1:0]  r_mask;
    logic [N-1:0]  w_mask_nxt;
    logic [3:0]    r_timer;
    logic [3:0]    w_timer_nxt;
    logic [3:0]    r_lcnt;
    logic [3:0]    w_lcnt_nxt;
    logic [BW-1:0] r_cost;
    logic [BW-1:0] w_cost_nxt;
    logic [31:0]   r_rlen;
    logic [31:0]   w_rlen_nxt;
    logic [31:0]   r_rcnt;
    logic [31:0]   w_rcnt_nxt;
    logic [2:0]    w_err_nxt;
    logic          w_bal_we;
    logic          w_start;
    logic          w_finish;
    logic          w_active;
    logic [BW-1:0] w_data_bw;

    logic [BW-1:0] r_bal [N];
    logic [BW-1:0] w_tmp_nxt [N];
    logic [BW-1:0] w_tot_nxt [N];
    logic [BW-1:0] w_chg_nxt [N];
    logic [1:0]    w_berr_nxt [N];
    logic [N-1:0]  w_ack_nxt;

    logic [BW-1:0] w_best;
    logic [IW-1:0] w_widx;
    logic          w_found;
    logic [N-1:0]  w_win_oh;

    logic [N-1:0]   r_ack;
    logic [2*N-1:0] r_berr;
    logic [N-1:0]   r_win;
    logic           r_ready;
    logic [2:0]     r_err;
    logic           r_round_over;
    logic [BW-1:0]  r_max_bid;

    assign w_op      = op_e'(C_op);
    assign w_data_bw = BW'(C_data);
    assign w_active  = (r_state == ST_ACTIVE);

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            bid_lane #(
                .AW(AW),
                .BW(BW)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .i_load    (w_start),
                .i_active  (w_active),
                .i_mask    (r_mask[g]),
                .i_bid     (bid[g]),
                .i_retract (retract[g]),
                .i_amt     (bid_amt[g*AW +: AW]),
                .i_cost    (r_cost),
                .i_bal     (r_bal[g]),
                .o_tmp_nxt (w_tmp_nxt[g]),
                .o_tot_nxt (w_tot_nxt[g]),
                .o_chg_nxt (w_chg_nxt[g]),
                .o_ack_nxt (w_ack_nxt[g]),
                .o_berr_nxt(w_berr_nxt[g])
            );
            assign balance[g*BW +: BW] = r_bal[g];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = ERR_OK;
        w_key_nxt   = r_key;
        w_mask_nxt  = r_mask;
        w_timer_nxt = r_timer;
        w_cost_nxt  = r_cost;
        w_rlen_nxt  = r_rlen;
        w_lcnt_nxt  = r_lcnt;
        w_rcnt_nxt  = r_rcnt;
        w_bal_we    = 1'b0;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (C_start) begin
                    w_err_nxt = ERR_START;
                end else begin
                    case (w_op)
                        OP_NOP:         ;
                        OP_UNLOCK:      w_err_nxt = ERR_UNLOCKED;
                        OP_LOCK: begin
                            w_key_nxt   = C_data;
                            w_state_nxt = ST_LOCKED;
                        end
                        OP_LOADBAL: begin
                            if (int'(C_idx) < N) w_bal_we = 1'b1;
                            else                 w_err_nxt = ERR_INVOP;
                        end
                        OP_SETMASK:     w_mask_nxt  = C_data[N-1:0];
                        OP_SETTIMER:    w_timer_nxt = C_data[3:0];
                        OP_BIDCHARGE:   w_cost_nxt  = w_data_bw;
                        OP_SETROUNDLEN: w_rlen_nxt  = C_data;
                        default:        w_err_nxt   = ERR_INVOP;
                    endcase
                end
            end
            // OVER shares the LOCKED command rules; a rejected opcode drops it back to LOCKED.
            ST_LOCKED, ST_OVER: begin
                if (C_start) begin
                    w_start     = 1'b1;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = ST_ACTIVE;
                end else if (w_op == OP_UNLOCK) begin
                    if (C_data == r_key) begin
                        w_state_nxt = ST_UNLOCKED;
                    end else begin
                        w_err_nxt   = ERR_BADKEY;
                        w_lcnt_nxt  = r_timer;
                        w_state_nxt = ST_LOCKOUT;
                    end
                end else if (w_op != OP_NOP) begin
                    w_err_nxt   = ERR_INVOP;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                w_err_nxt = ERR_BADKEY;
                if (r_lcnt <= 4'd1) w_state_nxt = ST_LOCKED;
                else                w_lcnt_nxt  = r_lcnt - 4'd1;
            end
            ST_ACTIVE: begin
                w_rcnt_nxt = r_rcnt + 32'd1;
                if ((bid & retract) != '0) w_err_nxt = ERR_INVOP;
                if (!C_start || ((r_rlen != '0) && (r_rcnt == r_rlen - 32'd1))) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_OVER;
                end
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
    end

    // Winner is chosen from the post-update totals so a bid in the last cycle counts.
    always_comb begin
        w_best   = '0;
        w_widx   = '0;
        w_found  = 1'b0;
        w_win_oh = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_tot_nxt[i] > w_best) begin
                w_best  = w_tot_nxt[i];
                w_widx  = IW'(i);
                w_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (w_found && (w_widx == IW'(i))) w_win_oh[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_UNLOCKED;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key        <= '0;
            r_mask       <= '1;
            r_timer      <= RST_TIMER;
            r_lcnt       <= '0;
            r_cost       <= BW'(1);
            r_rlen       <= '0;
            r_rcnt       <= '0;
            r_ack        <= '0;
            r_berr       <= '0;
            r_win        <= '0;
            r_ready      <= 1'b0;
            r_err        <= ERR_OK;
            r_round_over <= 1'b0;
            r_max_bid    <= '0;
            for (int unsigned i = 0; i < N; i++) r_bal[i] <= '0;
        end else begin
            r_key        <= w_key_nxt;
            r_mask       <= w_mask_nxt;
            r_timer      <= w_timer_nxt;
            r_lcnt       <= w_lcnt_nxt;
            r_cost       <= w_cost_nxt;
            r_rlen       <= w_rlen_nxt;
            r_rcnt       <= w_rcnt_nxt;
            r_ack        <= w_ack_nxt;
            r_err        <= w_err_nxt;
            r_ready      <= (w_state_nxt != ST_LOCKOUT);
            r_round_over <= (w_state_nxt == ST_OVER);
            if (w_finish) begin
                r_win     <= w_win_oh;
                r_max_bid <= w_best;
            end else if (w_state_nxt != ST_OVER) begin
                r_win     <= '0;
                r_max_bid <= '0;
            end
            for (int unsigned i = 0; i < N; i++) begin
                r_berr[2*i +: 2] <= w_berr_nxt[i];
                if (w_finish) begin
                    r_bal[i] <= w_win_oh[i] ? w_tmp_nxt[i] : (r_bal[i] - w_chg_nxt[i]);
                end else if (w_bal_we && (C_idx == IW'(i))) begin
                    r_bal[i] <= w_data_bw;
                end
            end
        end
    end

    assign ack        = r_ack;
    assign bid_err    = r_berr;
    assign win        = r_win;
    assign ready      = r_ready;
    assign err        = r_err;
    assign round_over = r_round_over;
    assign max_bid    = r_max_bid;

endmodule
